// File: rtl/msk_frame_sync.sv
// MSK frame synchroniser: finds the sync word (either polarity, Hamming-tolerant)
// in the recovered bit stream, then packs the fixed-length payload into bytes.
module msk_frame_sync #(
  parameter int unsigned          SYNC_W        = 32,
  parameter logic [SYNC_W-1:0]    SYNC_WORD     = SYNC_W'(32'h1ACF_FC1D),
  parameter int unsigned          MAX_ERR       = 2,
  parameter int unsigned          PAYLOAD_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_i,
  input  logic        data_val_i,
  output logic [7:0]  byte_o,
  output logic        byte_val_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic        sync_det_o,
  output logic        locked_o,
  output logic        inverted_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned DIST_W     = $clog2(SYNC_W + 1);
  localparam int unsigned TOTAL_BITS = PAYLOAD_BYTES * 8;
  localparam int unsigned BIT_W      = $clog2(TOTAL_BITS + 1);

  typedef enum logic {ST_SEARCH = 1'b0, ST_PAYLOAD = 1'b1} state_t;

  state_t              r_state;
  logic [SYNC_W-1:0]   r_shift;
  logic [DIST_W-1:0]   r_fill;
  logic [BIT_W-1:0]    r_bitcnt;
  logic [7:0]          r_pack;
  logic [7:0]          r_byte;
  logic                r_byte_val;
  logic                r_sof;
  logic                r_eof;
  logic                r_sync_det;
  logic                r_locked;
  logic                r_inv;
  logic [15:0]         r_frame_cnt;

  logic [SYNC_W-1:0]   w_shift_nx;
  logic [DIST_W-1:0]   w_fill_nx;
  logic [DIST_W-1:0]   w_dist_n;
  logic [DIST_W-1:0]   w_dist_i;
  logic                w_full;
  logic                w_hit_n;
  logic                w_hit_i;
  logic [BIT_W-1:0]    w_bit_nx;
  logic [7:0]          w_pack_nx;

  assign w_shift_nx = {r_shift[SYNC_W-2:0], data_i};
  assign w_fill_nx  = (r_fill == DIST_W'(SYNC_W)) ? r_fill : r_fill + DIST_W'(1);
  assign w_full     = (w_fill_nx == DIST_W'(SYNC_W));
  assign w_bit_nx   = r_bitcnt + BIT_W'(1);
  assign w_pack_nx  = {r_pack[6:0], data_i ^ r_inv};

  // Hamming distance of the post-shift window to the sync word and its complement
  always_comb begin
    w_dist_n = '0;
    w_dist_i = '0;
    for (int i = 0; i < int'(SYNC_W); i++) begin
      w_dist_n = w_dist_n + DIST_W'(w_shift_nx[i] ^ SYNC_WORD[i]);
      w_dist_i = w_dist_i + DIST_W'(w_shift_nx[i] ^ ~SYNC_WORD[i]);
    end
  end

  assign w_hit_n = (32'(w_dist_n) <= MAX_ERR);
  assign w_hit_i = (32'(w_dist_i) <= MAX_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_SEARCH;
      r_shift     <= '0;
      r_fill      <= '0;
      r_bitcnt    <= '0;
      r_pack      <= '0;
      r_byte      <= '0;
      r_byte_val  <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_sync_det  <= 1'b0;
      r_locked    <= 1'b0;
      r_inv       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_byte_val <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_sync_det <= 1'b0;
      if (data_val_i) begin
        case (r_state)
          ST_SEARCH: begin
            r_shift <= w_shift_nx;
            r_fill  <= w_fill_nx;
            // normal polarity wins when both windows are within tolerance
            if (w_full && (w_hit_n || w_hit_i)) begin
              r_state     <= ST_PAYLOAD;
              r_locked    <= 1'b1;
              r_sync_det  <= 1'b1;
              r_inv       <= ~w_hit_n;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_bitcnt    <= '0;
            end
          end
          ST_PAYLOAD: begin
            r_pack   <= w_pack_nx;
            r_bitcnt <= w_bit_nx;
            if (w_bit_nx[2:0] == 3'd0) begin
              r_byte     <= w_pack_nx;
              r_byte_val <= 1'b1;
              r_sof      <= (w_bit_nx == BIT_W'(8));
              r_eof      <= (w_bit_nx == BIT_W'(TOTAL_BITS));
            end
            // frame end: restart search from an empty window
            if (w_bit_nx == BIT_W'(TOTAL_BITS)) begin
              r_state  <= ST_SEARCH;
              r_locked <= 1'b0;
              r_shift  <= '0;
              r_fill   <= '0;
              r_bitcnt <= '0;
            end
          end
          default: r_state <= ST_SEARCH;
        endcase
      end
    end
  end

  assign byte_o      = r_byte;
  assign byte_val_o  = r_byte_val;
  assign sof_o       = r_sof;
  assign eof_o       = r_eof;
  assign sync_det_o  = r_sync_det;
  assign locked_o    = r_locked;
  assign inverted_o  = r_inv;
  assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_msk_frame_sync.sv
// Randomised bench for msk_frame_sync: a bit-level behavioural model predicts every
// output each cycle, plus directed frame-content checks per scenario.
module tb_msk_frame_sync;

  localparam int          SW    = 32;
  localparam logic [31:0] SYNC  = 32'h1ACF_FC1D;
  localparam int          PB    = 16;
  localparam int          ME    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_i = 1'b0;
  logic        data_val_i = 1'b0;
  logic [7:0]  byte_o;
  logic        byte_val_o, sof_o, eof_o, sync_det_o, locked_o, inverted_o;
  logic [15:0] frame_cnt_o;
  logic [7:0]  d3_byte_o;
  logic        d3_byte_val_o, d3_sof_o, d3_eof_o, d3_sync_det_o, d3_locked_o, d3_inverted_o;
  logic [15:0] d3_frame_cnt_o;

  msk_frame_sync dut (
    .clk(clk), .rst(rst), .data_i(data_i), .data_val_i(data_val_i),
    .byte_o(byte_o), .byte_val_o(byte_val_o), .sof_o(sof_o), .eof_o(eof_o),
    .sync_det_o(sync_det_o), .locked_o(locked_o), .inverted_o(inverted_o),
    .frame_cnt_o(frame_cnt_o)
  );

  msk_frame_sync #(.MAX_ERR(3)) dut3 (
    .clk(clk), .rst(rst), .data_i(data_i), .data_val_i(data_val_i),
    .byte_o(d3_byte_o), .byte_val_o(d3_byte_val_o), .sof_o(d3_sof_o), .eof_o(d3_eof_o),
    .sync_det_o(d3_sync_det_o), .locked_o(d3_locked_o), .inverted_o(d3_inverted_o),
    .frame_cnt_o(d3_frame_cnt_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state (bit history window, payload progress) and predicted outputs
  bit          m_locked;
  bit          hist[$];
  int          m_nbits;
  logic [7:0]  m_byte;
  logic        e_sync, e_bv, e_sof, e_eof, e_locked, e_inv;
  logic [7:0]  e_byte;
  logic [15:0] e_fcnt;

  task automatic model_reset();
    m_locked = 0; hist.delete(); m_nbits = 0; m_byte = 0;
    e_sync = 0; e_bv = 0; e_sof = 0; e_eof = 0; e_locked = 0; e_inv = 0;
    e_byte = 0; e_fcnt = 0;
  endtask

  task automatic model_step(input logic v, input logic b);
    logic [31:0] w;
    int d0, d1;
    e_sync = 0; e_bv = 0; e_sof = 0; e_eof = 0;
    if (!v) return;
    if (!m_locked) begin
      hist.push_back(b);
      if (hist.size() > SW) void'(hist.pop_front());
      if (hist.size() == SW) begin
        w = 0;
        for (int i = 0; i < SW; i++) w = {w[30:0], hist[i]};
        d0 = $countones(w ^ SYNC);
        d1 = $countones(w ^ ~SYNC);
        if (d0 <= ME || d1 <= ME) begin
          m_locked = 1; e_locked = 1; e_sync = 1; m_nbits = 0;
          e_inv  = (d0 <= ME) ? 1'b0 : 1'b1;
          e_fcnt = e_fcnt + 16'd1;
        end
      end
    end else begin
      m_byte = {m_byte[6:0], b ^ e_inv};
      m_nbits++;
      if (m_nbits % 8 == 0) begin
        e_bv = 1; e_byte = m_byte;
        e_sof = (m_nbits == 8);
        e_eof = (m_nbits == PB * 8);
        if (e_eof) begin
          m_locked = 0; e_locked = 0; hist.delete(); m_nbits = 0;
        end
      end
    end
  endtask

  // Observed traffic for directed checks
  logic [7:0] rx_q[$];
  bit         rx_sof[$], rx_eof[$];
  int         n_sync, d3_nbytes, d3_nsof, d3_neof, d3_nsync;
  logic [7:0] d3_last;
  logic [7:0] exp_q[$];
  logic [7:0] pl [PB];
  int         duty_pct = 100;

  task automatic clear_rx();
    rx_q.delete(); rx_sof.delete(); rx_eof.delete(); exp_q.delete();
    n_sync = 0; d3_nbytes = 0; d3_nsof = 0; d3_neof = 0; d3_nsync = 0; d3_last = 0;
  endtask

  task automatic cycle(input logic v, input logic b);
    data_val_i = v; data_i = b;
    @(posedge clk); #1;
    if (rst) model_reset(); else model_step(v, b);
    chk("sync_det", 32'(sync_det_o), 32'(e_sync));
    chk("byte_val", 32'(byte_val_o), 32'(e_bv));
    chk("sof", 32'(sof_o), 32'(e_sof));
    chk("eof", 32'(eof_o), 32'(e_eof));
    chk("locked", 32'(locked_o), 32'(e_locked));
    chk("inverted", 32'(inverted_o), 32'(e_inv));
    chk("frame_cnt", 32'(frame_cnt_o), 32'(e_fcnt));
    if (e_bv) chk("byte", 32'(byte_o), 32'(e_byte));
    if (byte_val_o) begin rx_q.push_back(byte_o); rx_sof.push_back(sof_o); rx_eof.push_back(eof_o); end
    if (sync_det_o) n_sync++;
    if (d3_byte_val_o) begin d3_nbytes++; d3_last = d3_byte_o; end
    if (d3_byte_val_o && d3_sof_o) d3_nsof++;
    if (d3_byte_val_o && d3_eof_o) d3_neof++;
    if (d3_sync_det_o) d3_nsync++;
  endtask

  task automatic send_bit(input logic b);
    int g = 0;
    while (duty_pct < 100 && $urandom_range(99) >= duty_pct && g < 40) begin
      cycle(1'b0, 1'($urandom_range(1)));
      g++;
    end
    cycle(1'b1, b);
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic set_ramp();
    for (int j = 0; j < PB; j++) pl[j] = 8'(j);
  endtask

  task automatic send_frame(input logic [31:0] sw, input bit inv);
    send_bits(sw, 32);
    for (int j = 0; j < PB; j++) begin
      send_bits(32'(pl[j] ^ (inv ? 8'hFF : 8'h00)), 8);
      exp_q.push_back(pl[j]);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
    clear_rx();
  endtask

  function automatic logic [31:0] flip_mask(input int n);
    logic [31:0] m = 0;
    int c = 0;
    while (c < n) begin
      int p = $urandom_range(31);
      if (!m[p]) begin m[p] = 1'b1; c++; end
    end
    return m;
  endfunction

  task automatic check_frames(input string tag, input int nf);
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(nf * PB));
    chk({tag, "_nsync"}, 32'(n_sync), 32'(nf));
    chk({tag, "_fcnt"}, 32'(frame_cnt_o), 32'(nf));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_data"}, 32'(rx_q[i]), 32'(exp_q[i]));
      chk({tag, "_sofflag"}, 32'(rx_sof[i]), 32'(i % PB == 0));
      chk({tag, "_eofflag"}, 32'(rx_eof[i]), 32'(i % PB == PB - 1));
    end
  endtask

  initial begin
    #1;
    chk("rst_byte_val", 32'(byte_val_o), 0);
    chk("rst_locked", 32'(locked_o), 0);
    chk("rst_fcnt", 32'(frame_cnt_o), 0);
    chk("rst_byte", 32'(byte_o), 0);
    model_reset();
    apply_reset();

    // clean frame, normal polarity
    set_ramp(); send_random(40); send_frame(SYNC, 0); idle(4);
    check_frames("basic", 1);
    chk("basic_inv", 32'(inverted_o), 0);

    // fully inverted frame
    apply_reset();
    set_ramp(); send_random(40); send_frame(~SYNC, 1); idle(4);
    check_frames("invert", 1);
    chk("invert_inv", 32'(inverted_o), 1);

    // two bit errors in sync: accepted
    apply_reset();
    set_ramp(); send_random(40); send_frame(SYNC ^ flip_mask(2), 0); idle(4);
    check_frames("err2", 1);

    // three bit errors: rejected at MAX_ERR=2, accepted at MAX_ERR=3
    apply_reset();
    set_ramp(); send_random(40); send_frame(SYNC ^ flip_mask(3), 0); idle(4);
    chk("err3_nsync", 32'(n_sync), 0);
    chk("err3_nbytes", 32'(rx_q.size()), 0);
    chk("err3_me3_nsync", 32'(d3_nsync), 1);
    chk("err3_me3_nbytes", 32'(d3_nbytes), 32'(PB));
    chk("err3_me3_sof", 32'(d3_nsof), 1);
    chk("err3_me3_eof", 32'(d3_neof), 1);
    chk("err3_me3_last", 32'(d3_last), 32'h0F);
    chk("err3_me3_fcnt", 32'(d3_frame_cnt_o), 1);
    chk("err3_me3_inv", 32'(d3_inverted_o), 0);
    chk("err3_me3_locked", 32'(d3_locked_o), 0);

    // sync word embedded in payload, then two back-to-back frames
    apply_reset();
    set_ramp();
    pl[4] = 8'h1A; pl[5] = 8'hCF; pl[6] = 8'hFC; pl[7] = 8'h1D;
    send_random(40); send_frame(SYNC, 0);
    set_ramp(); send_frame(SYNC, 0); send_frame(SYNC, 0); idle(4);
    check_frames("embed", 3);

    // reset mid-frame after payload byte 5
    apply_reset();
    set_ramp(); send_random(40);
    send_bits(SYNC, 32);
    for (int j = 0; j < 6; j++) send_bits(32'(pl[j]), 8);
    send_bits(32'h5, 3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_byte_val", 32'(byte_val_o), 0);
    chk("midrst_locked", 32'(locked_o), 0);
    chk("midrst_fcnt", 32'(frame_cnt_o), 0);
    chk("midrst_inv", 32'(inverted_o), 0);
    chk("midrst_byte", 32'(byte_o), 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(1)));
    rst = 1'b0;
    clear_rx();
    send_bits(32'hA5, 5); idle(6);
    chk("midrst_nobytes", 32'(rx_q.size()), 0);
    clear_rx();
    send_random(40); send_frame(SYNC, 0); idle(4);
    check_frames("postrst", 1);

    // gapped valid stream at several duty cycles
    for (int k = 0; k < 3; k++) begin
      apply_reset();
      duty_pct = (k == 0) ? 10 : (k == 1) ? 45 : int'($urandom_range(100, 10));
      set_ramp(); send_random(40); send_frame(SYNC, 0);
      duty_pct = 100; idle(4);
      check_frames("gaps", 1);
      chk("gaps_inv", 32'(inverted_o), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

endmodule
